// File: rtl/rh_axi4_slv_mem_pkg.sv
// Shared AXI4 types for the memory slave: burst and response encodings,
// FSM state types, and the per-burst legality check.
package rh_axi4_slv_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  // Bit n set means a WRAP burst of len n (n+1 beats) is legal: len 1, 3, 7, 15.
  localparam logic [15:0] WRAP_LEN_OK = 16'h808A;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Burst-level error: oversize beat, reserved burst type, or illegal wrap length.
  function automatic logic burst_illegal(input logic [2:0] size,
                                         input logic [7:0] len,
                                         input logic [1:0] burst,
                                         input logic [2:0] max_size);
    logic bad;
    bad = (size > max_size) || (burst == 2'b11);
    if (burst == BURST_WRAP && !((len < 8'd16) && WRAP_LEN_OK[len[3:0]]))
      bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/rh_axi4_slv_mem_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED / INCR / WRAP bursts.
module rh_axi4_addr_gen
  import rh_axi4_slv_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] container;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] inc_addr;

  // Wrap keeps the upper bits of the aligned container and lets the low bits roll over.
  always_comb begin
    step      = ADDR_W'(1) << size;
    container = ADDR_W'({1'b0, len} + 9'd1) << size;
    wrap_mask = container - ADDR_W'(1);
    inc_addr  = addr + step;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = inc_addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (inc_addr & wrap_mask);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/rh_axi4_slv_mem.sv
// AXI4 slave backed by a word-addressed memory. Independent write and read
// FSMs, one burst each in flight, with per-burst and per-beat SLVERR.
module rh_axi4_slv_mem
  import rh_axi4_slv_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [2:0]      MAX_SIZE = 3'(OFF);
  localparam logic [ADDR_W:0] MEM_LIM  = (ADDR_W + 1)'(MEM_WORDS * STRB_W);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < MEM_LIM;
  endfunction

  function automatic logic [IDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
    return a[OFF +: IDX_W];
  endfunction

  // ---------------- write channel ----------------
  w_state_e          w_state;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic [7:0]        w_beat;
  logic              w_burst_err;
  logic              w_resp_err;
  logic [ADDR_W-1:0] w_next;
  logic              w_hs;
  logic              w_last_beat;
  logic              w_beat_err;
  logic              w_do_write;

  rh_axi4_addr_gen #(.ADDR_W(ADDR_W)) u_w_addr_gen (
    .addr      (w_addr),
    .size      (w_size),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next)
  );

  // Per-beat write qualifiers; a WLAST mismatch flags the response but still writes.
  always_comb begin
    w_hs        = (w_state == W_DATA) && WVALID && WREADY;
    w_last_beat = (w_beat == w_len);
    w_beat_err  = !in_range(w_addr) || (WLAST != w_last_beat);
    w_do_write  = w_hs && !ARESET && !w_burst_err && in_range(w_addr);
  end

  // Write FSM: AW latch, beat counting on the slave's own count, B response.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state     <= W_IDLE;
      AWREADY     <= 1'b0;
      WREADY      <= 1'b0;
      BVALID      <= 1'b0;
      BID         <= '0;
      BRESP       <= '0;
      w_id        <= '0;
      w_addr      <= '0;
      w_len       <= '0;
      w_size      <= '0;
      w_burst     <= '0;
      w_beat      <= '0;
      w_burst_err <= 1'b0;
      w_resp_err  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            w_id        <= AWID;
            w_addr      <= AWADDR;
            w_len       <= AWLEN;
            w_size      <= AWSIZE;
            w_burst     <= AWBURST;
            w_beat      <= '0;
            w_burst_err <= burst_illegal(AWSIZE, AWLEN, AWBURST, MAX_SIZE);
            w_resp_err  <= burst_illegal(AWSIZE, AWLEN, AWBURST, MAX_SIZE);
            AWREADY     <= 1'b0;
            WREADY      <= 1'b1;
            w_state     <= W_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr     <= w_next;
            w_beat     <= w_beat + 8'd1;
            w_resp_err <= w_resp_err || w_beat_err;
            if (w_last_beat) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BID     <= w_id;
              BRESP   <= (w_resp_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane writes for accepted beats that are in range and in a legal burst.
  always_ff @(posedge ACLK) begin
    if (w_do_write) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (WSTRB[i]) mem[widx(w_addr)][i*8 +: 8] <= WDATA[i*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e          r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [7:0]        r_beat;
  logic              r_burst_err;
  logic [ADDR_W-1:0] r_next;
  logic              ar_illegal;
  logic [ADDR_W-1:0] r_load_addr;
  logic              r_load_bad;
  logic [DATA_W-1:0] r_load_data;

  rh_axi4_addr_gen #(.ADDR_W(ADDR_W)) u_r_addr_gen (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (r_next)
  );

  // Data for the beat about to be presented: first beat from ARADDR, later ones from r_next.
  always_comb begin
    ar_illegal  = burst_illegal(ARSIZE, ARLEN, ARBURST, MAX_SIZE);
    r_load_addr = (r_state == R_IDLE) ? ARADDR : r_next;
    r_load_bad  = ((r_state == R_IDLE) ? ar_illegal : r_burst_err) || !in_range(r_load_addr);
    r_load_data = r_load_bad ? '0 : mem[widx(r_load_addr)];
  end

  // Read FSM: AR latch, registered R beat, advance on each R handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= R_IDLE;
      ARREADY     <= 1'b0;
      RVALID      <= 1'b0;
      RLAST       <= 1'b0;
      RID         <= '0;
      RDATA       <= '0;
      RRESP       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_beat      <= '0;
      r_burst_err <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            RID         <= ARID;
            r_addr      <= ARADDR;
            r_len       <= ARLEN;
            r_size      <= ARSIZE;
            r_burst     <= ARBURST;
            r_beat      <= '0;
            r_burst_err <= ar_illegal;
            RDATA       <= r_load_data;
            RRESP       <= r_load_bad ? RESP_SLVERR : RESP_OKAY;
            RLAST       <= (ARLEN == 8'd0);
            RVALID      <= 1'b1;
            ARREADY     <= 1'b0;
            r_state     <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_beat <= r_beat + 8'd1;
              RDATA  <= r_load_data;
              RRESP  <= r_load_bad ? RESP_SLVERR : RESP_OKAY;
              RLAST  <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rh_axi4_slv_mem.md
# rh_axi4_slv_mem

Synthesizable AXI4 slave endpoint backed by an internal word-addressed memory, the responder side for the AXI4 master agent. It accepts one write burst and one read burst at a time, independently, with FIXED/INCR/WRAP bursts, narrow transfers and WSTRB byte enables. It returns OKAY or SLVERR. It is instantiated in VIP self-test benches and in small subsystem benches as the default memory target.

## Interface
- ADDR_W, 16, AxADDR width (byte address)
- DATA_W, 32, data width; power of two, 8..128
- ID_W, 4, AxID/xID width
- MEM_WORDS, 256, memory depth in DATA_W words; byte range 0 .. MEM_WORDS*DATA_W/8-1
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/8/3/2  write address
- AWVALID in 1, AWREADY out 1
- WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data
- WVALID in 1, WREADY out 1
- BID/BRESP  out  ID_W/2  write response
- BVALID out 1, BREADY in 1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/8/3/2  read address
- ARVALID in 1, ARREADY out 1
- RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data
- RVALID out 1, RREADY in 1

## Operation
- Write FSM states: W_IDLE, W_DATA, W_RESP. AWREADY=1 only in W_IDLE. AW handshake latches id/addr/len/size/burst and moves to W_DATA. WREADY=1 only in W_DATA. Each W handshake writes the bytes enabled by WSTRB at the current beat address, then advances the address and the beat count. The handshake on beat AWLEN moves to W_RESP. BVALID=1 in W_RESP. B handshake returns to W_IDLE.
- Read FSM states: R_IDLE, R_DATA. ARREADY=1 only in R_IDLE. AR handshake latches fields, loads RDATA from the first beat address, and moves to R_DATA. In R_DATA, RVALID=1 and RLAST=(beat==ARLEN). Each R handshake loads the next beat's data. The handshake with RLAST returns to R_IDLE.
- Address generation:
  - FIXED: address constant.
  - INCR: next = addr + (1<<size).
  - WRAP: container = (len+1)<<size, aligned to the container; next wraps within it.
  - Computed in ADDR_W bits; overflow wraps mod 2^ADDR_W.
- Memory index = addr >> log2(DATA_W/8), with lanes selected by the low address bits.
- SLVERR conditions, evaluated per burst at the A handshake and latched:
  - size > log2(DATA_W/8)
  - WRAP with len not in {1,3,7,15}
  - burst==2'b11
- SLVERR conditions, evaluated per beat:
  - beat address outside the memory range.
- SLVERR effects: writes to erroring beats are dropped, and BRESP=SLVERR if any beat erred. Read beats that err return RDATA=0 and RRESP=SLVERR for that beat only.
- WLAST mismatch: the slave ends the burst on its own beat count. A WLAST that is early, or missing on beat AWLEN, forces BRESP=SLVERR. Memory is still written for all accepted beats.
- Read and write channels are fully independent. They may be active concurrently.

## Timing
- Reset values: AWREADY=ARREADY=WREADY=BVALID=RVALID=RLAST=0. BID, RID, BRESP, RRESP and RDATA are all 0. Both FSMs go to idle. Memory contents are not reset.
- Reset mid-burst aborts both FSMs in the next cycle. No B or R response is issued for the aborted bursts.
- AW handshake at cycle N gives WREADY=1 from N+1. Last W handshake at M gives BVALID=1 at M+1, held until BREADY. AWREADY=1 again the cycle after the B handshake.
- AR handshake at N gives RVALID=1 at N+1. With RREADY held high there is one beat per cycle. ARREADY=1 the cycle after the RLAST handshake.
- Outputs are stable while VALID=1 and READY=0.
- Read-during-write to the same word in the same cycle returns the old data. A read beat loaded one cycle or more after the write handshake returns the new data.

## Structure
- Shared package types, to be added to the common AXI4 types include: burst enum {FIXED, INCR, WRAP}, resp enum {OKAY, EXOKAY, SLVERR, DECERR}, and the wrap-length legality constant.
- Sub-module rh_axi4_addr_gen: combinational next-address and aligned-wrap computation from (addr, size, len, burst). Both FSMs instantiate it.

## Test plan
- INCR write: AWADDR=0x10, LEN=3, SIZE=2, WSTRB=0xF, data 1..4. Then read the same burst → RDATA 1,2,3,4, RLAST on beat 3, all responses OKAY.
- WRAP read: ARADDR=0x38, LEN=3, SIZE=2 → beat addresses 0x38, 0x3C, 0x30, 0x34.
- Narrow strobe write: AWADDR=0x21, SIZE=0, WSTRB=0x2, WDATA=0xAB00. Then a 32-bit read at 0x20 → byte1=0xAB, other bytes unchanged.
- Out-of-range INCR read starting at the last valid word, LEN=1 → beat0 OKAY with data, beat1 SLVERR with RDATA=0.
- Backpressure: BREADY low for 5 cycles and RREADY toggling every cycle → BVALID held, and each R beat is stable until accepted. Run with a concurrent read and write.
- Protocol and reset errors:
  - Early WLAST on beat 1 of LEN=3 → 4 beats accepted, BRESP=SLVERR.
  - ARESET asserted mid-read → RVALID=0 the next cycle, and ARREADY=1 after reset is released.
